// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment width,
// blank pattern, hex glyph table and a one-hot helper.
package seg_pkg;

   localparam int SEG_W = 7;

   // Active-high pattern with every segment dark
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

   // Active-high glyphs, bit order {g,f,e,d,c,b,a}; element [n] is the glyph for hex digit n
   localparam logic [15:0][SEG_W-1:0] GLYPH = {
      7'b1110001,   // F
      7'b1111001,   // E
      7'b1011110,   // d
      7'b0111001,   // C
      7'b1111100,   // b
      7'b1110111,   // A
      7'b1101111,   // 9
      7'b1111111,   // 8
      7'b0000111,   // 7
      7'b1111101,   // 6
      7'b1101101,   // 5
      7'b1100110,   // 4
      7'b1001111,   // 3
      7'b1011011,   // 2
      7'b0000110,   // 1
      7'b0111111    // 0
   };

   // One-hot of a digit index, wide enough for the largest supported display
   function automatic logic [7:0] onehot(input logic [2:0] idx);
      return 8'd1 << idx;
   endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-high seven-segment glyph.
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0]       nib_i,
   output logic [SEG_W-1:0] seg_o
);

   // Table lookup; every nibble value has a glyph
   always_comb begin
      seg_o = GLYPH[nib_i];
   end

endmodule

// File: rtl/seg_scan_disp.sv
// Multiplexed seven-segment driver: synchronises the counter value, keeps a
// history of the last NUM_DIGITS distinct values and scans it across the digits.
module seg_scan_disp
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 1000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            din,
   input  logic                  din_en,
   input  logic                  clr,
   output logic [SEG_W-1:0]      seg,
   output logic                  dp,
   output logic [NUM_DIGITS-1:0] dig_sel
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [7:0]            OH0_FULL  = onehot(3'd0);
   localparam logic [NUM_DIGITS-1:0] OH0       = OH0_FULL[NUM_DIGITS-1:0];
   localparam logic [SEG_W-1:0]      SEG_RST   = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
   localparam logic                  DP_RST    = ACTIVE_LOW;
   localparam logic [NUM_DIGITS-1:0] DIG_RST   = ACTIVE_LOW ? ~OH0 : OH0;

   logic [3:0]            din_s1_q, din_s2_q, din_prev_q;
   logic [3:0]            hist_q [NUM_DIGITS];
   logic [3:0]            hist_d [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] vld_q, vld_d;
   logic [PW-1:0]         presc_q, presc_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [SEG_W-1:0]      seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;

   logic                  push;
   logic [SEG_W-1:0]      glyph;
   logic [7:0]            oh_full;

   // Two-flop synchroniser plus previous-value register for change detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         din_s1_q   <= '0;
         din_s2_q   <= '0;
         din_prev_q <= '0;
      end else begin
         din_s1_q   <= din;
         din_s2_q   <= din_s1_q;
         din_prev_q <= din_s2_q;
      end
   end

   // History shift: clear wins over a push in the same cycle
   always_comb begin
      push = din_en && (din_s2_q != din_prev_q);
      for (int i = 0; i < NUM_DIGITS; i++) begin
         hist_d[i] = hist_q[i];
         vld_d[i]  = vld_q[i];
      end
      if (clr) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            hist_d[i] = '0;
            vld_d[i]  = 1'b0;
         end
      end else if (push) begin
         hist_d[0] = din_s2_q;
         vld_d[0]  = 1'b1;
         for (int i = 1; i < NUM_DIGITS; i++) begin
            hist_d[i] = hist_q[i-1];
            vld_d[i]  = vld_q[i-1];
         end
      end
   end

   // History storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            hist_q[i] <= '0;
         end
         vld_q <= '0;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            hist_q[i] <= hist_d[i];
         end
         vld_q <= vld_d;
      end
   end

   // Scan sequencing: the prescaler wrap advances the digit index; never stalls
   always_comb begin
      presc_d = presc_q + 1'b1;
      idx_d   = idx_q;
      if (presc_q == PW'(SCAN_DIV - 1)) begin
         presc_d = '0;
         idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
   end

   seg_hex_decode u_dec (
      .nib_i (hist_q[idx_d]),
      .seg_o (glyph)
   );

   // Output pattern for the slot selected next; seg and dig_sel share one edge
   always_comb begin
      oh_full   = onehot(3'(idx_d));
      seg_d     = vld_q[idx_d] ? glyph : SEG_BLANK;
      dp_d      = (idx_d == '0) && vld_q[0];
      dig_sel_d = oh_full[NUM_DIGITS-1:0];
      if (ACTIVE_LOW) begin
         seg_d     = ~seg_d;
         dp_d      = ~dp_d;
         dig_sel_d = ~dig_sel_d;
      end
   end

   // Scan state and registered pin drivers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q   <= '0;
         idx_q     <= '0;
         seg_q     <= SEG_RST;
         dp_q      <= DP_RST;
         dig_sel_q <= DIG_RST;
      end else begin
         presc_q   <= presc_d;
         idx_q     <= idx_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
         dig_sel_q <= dig_sel_d;
      end
   end

   assign seg     = seg_q;
   assign dp      = dp_q;
   assign dig_sel = dig_sel_q;

endmodule

// File: tb/tb_seg_scan_disp.sv
// Bench for seg_scan_disp with NUM_DIGITS=4, SCAN_DIV=4, active-low pins.
module tb_seg_scan_disp;

   localparam int ND = 4;
   localparam int SD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] din = 4'd0;
   logic       din_en = 1'b1;
   logic       clr = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] dig_sel;

   int checks = 0;
   int failures = 0;

   seg_scan_disp #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .ACTIVE_LOW(1'b1)) dut (
      .clk     (clk),
      .rst     (rst),
      .din     (din),
      .din_en  (din_en),
      .clr     (clr),
      .seg     (seg),
      .dp      (dp),
      .dig_sel (dig_sel)
   );

   always #5 clk = ~clk;

   // Active-high glyph table, {g,f,e,d,c,b,a}
   logic [6:0] gl [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                           7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                           7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                           7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

   // Model state: history as a newest-first list, din samples of recent edges
   int         cyc = 0;
   logic [3:0] mh [ND] = '{default: 4'd0};
   logic       mv [ND] = '{default: 1'b0};
   logic [3:0] smp1 = 4'd0, smp2 = 4'd0, smp3 = 4'd0;
   logic [6:0] e_seg = 7'h7F;
   logic       e_dp = 1'b1;
   logic [3:0] e_dig = 4'b1110;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: digit shown after edge n is (n / SD) % ND since reset;
   // a value sampled at edge n-2 that differs from edge n-3 is pushed at edge n
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            cyc = 0;
            for (int i = 0; i < ND; i++) begin mh[i] = 4'd0; mv[i] = 1'b0; end
            smp1 = 4'd0; smp2 = 4'd0; smp3 = 4'd0;
            e_seg = 7'h7F; e_dp = 1'b1; e_dig = 4'b1110;
         end else begin
            int idx;
            cyc++;
            idx   = (cyc / SD) % ND;
            e_dig = ~(4'b0001 << idx);
            e_seg = mv[idx] ? ~gl[mh[idx]] : 7'h7F;
            e_dp  = !(idx == 0 && mv[0]);
            if (clr) begin
               for (int i = 0; i < ND; i++) begin mh[i] = 4'd0; mv[i] = 1'b0; end
            end else if (din_en && smp2 != smp3) begin
               for (int i = ND - 1; i > 0; i--) begin mh[i] = mh[i-1]; mv[i] = mv[i-1]; end
               mh[0] = smp2;
               mv[0] = 1'b1;
            end
            smp3 = smp2; smp2 = smp1; smp1 = din;
         end
      end
   end

   // Every-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         chk("seg", 32'(seg), 32'(e_seg));
         chk("dp", 32'(dp), 32'(e_dp));
         chk("dig_sel", 32'(dig_sel), 32'(e_dig));
         chk("dig_onehot", 32'($countones(~dig_sel)), 32'd1);
      end
   end

   task automatic hold(input logic [3:0] v, input int n);
      @(negedge clk);
      din = v;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic wait_dig(input logic [3:0] target);
      int n = 0;
      while (dig_sel !== target && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("wait_dig", 32'(dig_sel), 32'(target));
   endtask

   initial begin
      logic [3:0] a;
      int n;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_dp", 32'(dp), 32'd1);
      chk("rst_dig", 32'(dig_sel), 32'hE);
      rst = 1'b0;

      // Push sequence 0->3->7->A
      hold(4'h0, 10);
      hold(4'h3, 10);
      hold(4'h7, 10);
      hold(4'hA, 10);
      chk("m_push_h0", 32'(mh[0]), 32'hA);
      chk("m_push_h1", 32'(mh[1]), 32'h7);
      chk("m_push_h2", 32'(mh[2]), 32'h3);
      chk("m_push_v3", 32'(mv[3]), 32'd0);
      wait_dig(4'b1110);
      chk("push_seg0", 32'(seg), 32'(7'b0001000));
      chk("push_dp0", 32'(dp), 32'd0);
      wait_dig(4'b1101);
      chk("push_seg1", 32'(seg), 32'(7'b1111000));
      chk("push_dp1", 32'(dp), 32'd1);
      wait_dig(4'b0111);
      chk("push_seg3", 32'(seg), 32'h7F);

      // Rapid changes 1,2,3,4 on consecutive cycles
      hold(4'h1, 1);
      hold(4'h2, 1);
      hold(4'h3, 1);
      hold(4'h4, 10);
      chk("m_rapid_h0", 32'(mh[0]), 32'h4);
      chk("m_rapid_h3", 32'(mh[3]), 32'h1);
      wait_dig(4'b1110);
      chk("rapid_seg0", 32'(seg), 32'(7'b0011001));
      wait_dig(4'b0111);
      chk("rapid_seg3", 32'(seg), 32'(7'b1111001));

      // Frozen history while disabled, no push on re-enable with stable din
      @(negedge clk);
      din_en = 1'b0;
      hold(4'h5, 10);
      hold(4'h6, 10);
      din_en = 1'b1;
      repeat (10) @(negedge clk);
      chk("m_dis_h0", 32'(mh[0]), 32'h4);
      chk("m_dis_h1", 32'(mh[1]), 32'h3);
      wait_dig(4'b1110);
      chk("dis_seg0", 32'(seg), 32'(7'b0011001));

      // Clear coinciding with the push of 9
      @(negedge clk);
      din = 4'h9;
      @(negedge clk);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      repeat (6) @(negedge clk);
      chk("m_clr_v0", 32'(mv[0]), 32'd0);
      wait_dig(4'b1110);
      chk("clr_seg0", 32'(seg), 32'h7F);
      chk("clr_dp0", 32'(dp), 32'd1);
      hold(4'hB, 10);
      chk("m_clr_h0", 32'(mh[0]), 32'hB);
      chk("m_clr_v1", 32'(mv[1]), 32'd0);
      wait_dig(4'b1110);
      chk("b_seg0", 32'(seg), 32'(7'b0000011));

      // Scan rate: step every SD cycles, full rotation in ND*SD cycles
      a = dig_sel;
      n = 0;
      while (dig_sel === a && n < 20) begin
         @(negedge clk);
         n++;
      end
      a = dig_sel;
      repeat (3) @(negedge clk);
      chk("scan_hold", 32'(dig_sel), 32'(a));
      @(negedge clk);
      chk("scan_step", 32'(dig_sel), 32'({a[2:0], a[3]}));
      repeat (12) @(negedge clk);
      chk("scan_rot", 32'(dig_sel), 32'(a));

      // Reset mid-scan takes effect without a clock edge
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("arst_seg", 32'(seg), 32'h7F);
      chk("arst_dp", 32'(dp), 32'd1);
      chk("arst_dig", 32'(dig_sel), 32'hE);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_seg", 32'(seg), 32'h7F);
      repeat (20) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg_scan_disp.md
# seg_scan_disp

Multiplexed seven-segment display driver that consumes the 4-bit count from the synchronous counter stage. It samples the counter value on the system clock, pushes every new value into a NUM_DIGITS-deep digit history, and time-multiplexes that history across common-anode/cathode digits with a hex glyph decoder. It is the last stage before the board's display pins.

## Interface
- NUM_DIGITS, 4, number of display digits / history depth (1..8)
- SCAN_DIV, 1000, clk cycles each digit stays lit (>= 2)
- ACTIVE_LOW, 1, 1 = seg/dig_sel/dp driven active-low; 0 = active-high
- clk  in  1  system clock; the only clock
- rst  in  1  asynchronous reset, active-high
- din  in  4  counter value; may change on any clk edge, treated as asynchronous
- din_en  in  1  1 = value changes are captured; 0 = history frozen
- clr  in  1  synchronous clear of history
- seg  out  7  segments {g,f,e,d,c,b,a}
- dp  out  1  decimal point, lit on digit 0 (newest value) only
- dig_sel  out  NUM_DIGITS  one-hot digit enable

## Operation
- Input path: din through two flops (din_s1, din_s2); din_prev <= din_s2 every cycle.
- Push event: din_en && (din_s2 != din_prev). On push: buf[0] <= din_s2, buf[i] <= buf[i-1], vld[0] <= 1, vld[i] <= vld[i-1]; oldest entry discarded.
- clr: buf and vld all zero next cycle; clr beats a same-cycle push (push lost); din_prev still updates.
- Slots with vld=0 are blank: all segments and dp off, dig_sel still scans.
- Scan: prescaler counts 0..SCAN_DIV-1, wraps to 0; on wrap, idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1.
- Outputs registered: at each edge, dig_sel <= onehot(idx_next), seg <= glyph(buf[idx_next]) or blank, dp <= (idx_next==0 && vld[0]). seg and dig_sel change on the same edge, no ghosting cycle.
- Glyphs (active-high, gfedcba): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- ACTIVE_LOW=1 inverts seg, dp, dig_sel at the output register.

## Timing
- Reset values: din_s1/s2/din_prev/buf/vld = 0, prescaler = 0, idx = 0, seg = blank (7'h7F if ACTIVE_LOW else 0), dp off, dig_sel = digit 0 active.
- Reset mid-operation clears everything immediately; history is not preserved.
- din change to buf update: 3 clk edges (2 sync + compare/push).
- buf update to pins: visible on the next edge at which that slot's idx is selected; worst case NUM_DIGITS*SCAN_DIV + 1 cycles.
- Since din_prev resets to 0, a first value of 0 is not pushed; first nonzero value is.
- din unchanged for many cycles: exactly one push per change; counter wrap F->0 is a change and pushes 0.
- Prescaler width = $clog2(SCAN_DIV); idx width = $clog2(NUM_DIGITS), min 1.
- Scan does not stall on push/clr.

## Structure
- Package seg_pkg: SEG_W=7, SEG_BLANK, 16-entry glyph constant, function onehot.
- Sub-module seg_hex_decode (combinational 4-bit -> 7-bit glyph), instantiated once on the selected slot.
- Top holds synchronizer, change detect, history shift register, prescaler/scan FSM, output register.

## Test plan
- Reset: rst=1 mid-scan -> seg=7'h7F, dp=1, dig_sel=4'b1110 (ACTIVE_LOW) within same cycle, held until release.
- Push sequence (SCAN_DIV=4): din 0->3->7->A, each held 10 cycles -> buf = {0,3,7,A} (digit 0 = A); one full scan shows glyphs A,7,3 and blank for slot 3.
- Rapid change: din changes every cycle 1,2,3,4 -> four pushes, buf[0]=4, buf[3]=1.
- din_en=0 while din steps 5->6 -> no push, history unchanged; re-enable with din=6 stable -> still no push.
- clr asserted same cycle as a push of 9 -> all slots blank, 9 not stored; next change to B pushes B.
- Scan rate: SCAN_DIV=4, NUM_DIGITS=4 -> dig_sel advances exactly every 4 cycles, full rotation 16 cycles, one-hot at every cycle.
